// File: rtl/fetch_decode_pkg.sv
// Shared opcode constants for the instruction path (mirror of the def.h
// encodings used by imem and the execute datapath) and a small decode helper.
package fetch_decode_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_INC   = 4'h1;
   localparam logic [3:0] OP_COMP  = 4'h4;
   localparam logic [3:0] OP_CHECK = 4'h5;
   localparam logic [3:0] OP_JMP   = 4'h6;
   localparam logic [3:0] OP_JNO   = 4'h7;
   localparam logic [3:0] OP_JNZ   = 4'h8;

   // Opcodes whose datapath result comes back later as a flag_valid pulse.
   function automatic logic sets_flag(input logic [3:0] opc);
      return (opc == OP_COMP) || (opc == OP_CHECK);
   endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Instruction-memory, decoded-instruction handshake and flag-return bundle.
// master = fetch/decode block, slave = imem + execute datapath side.
interface fetch_decode_if #(
   parameter int PC_W = 8,
   parameter int OP_W = 16
);
   logic [PC_W-1:0] pc;
   logic [OP_W-1:0] op;
   logic            dec_valid;
   logic            dec_ready;
   logic [3:0]      dec_opcode;
   logic [3:0]      dec_dst;
   logic [3:0]      dec_src1;
   logic [3:0]      dec_src0;
   logic [7:0]      dec_imm;
   logic            flag_valid;
   logic            flag_in;
   logic            halted;

   modport master (
      output pc, dec_valid, dec_opcode, dec_dst, dec_src1, dec_src0, dec_imm, halted,
      input  op, dec_ready, flag_valid, flag_in
   );

   modport slave (
      input  pc, dec_valid, dec_opcode, dec_dst, dec_src1, dec_src0, dec_imm, halted,
      output op, dec_ready, flag_valid, flag_in
   );
endinterface

// File: rtl/fd_branch_eval.sv
// Combinational branch resolution for the op at the current pc: classifies
// JMP/JNO/JNZ, decides taken against the condition flag and picks next pc.
module fd_branch_eval
   import fetch_decode_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic [3:0]      i_opcode,
   input  logic [PC_W-1:0] i_imm,
   input  logic [PC_W-1:0] i_pc,
   input  logic            i_cond_flag,
   output logic            o_is_branch,
   output logic            o_taken,
   output logic [PC_W-1:0] o_next_pc,
   output logic            o_self_loop
);

   // Decode branch class and target; non-branches fall through to pc+1.
   always_comb begin
      o_is_branch = 1'b0;
      o_taken     = 1'b0;
      o_self_loop = 1'b0;
      case (i_opcode)
         OP_JMP: begin
            o_is_branch = 1'b1;
            o_taken     = 1'b1;
            o_self_loop = (i_imm == i_pc);
         end
         OP_JNO: begin
            o_is_branch = 1'b1;
            o_taken     = !i_cond_flag;
         end
         OP_JNZ: begin
            o_is_branch = 1'b1;
            o_taken     = i_cond_flag;
         end
         default: ;
      endcase
      o_next_pc = o_taken ? i_imm : i_pc + PC_W'(1);
   end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: drives pc into imem, registers the returned op into
// a decoded-instruction output register with valid/ready handshake, resolves
// jumps locally and tracks the outstanding COMP/CHECK flag result.
module fetch_decode
   import fetch_decode_pkg::*;
#(
   parameter int PC_W          = 8,
   parameter int OP_W          = 16,
   parameter int HALT_SELF_JMP = 1
) (
   input  logic           clk,
   input  logic           rst,
   fetch_decode_if.master bus
);

   typedef enum logic [1:0] {S_RUN, S_STALL, S_BWAIT, S_HALT} state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic            r_dec_valid;
   logic [3:0]      r_dec_opcode;
   logic [3:0]      r_dec_dst;
   logic [3:0]      r_dec_src1;
   logic [3:0]      r_dec_src0;
   logic [7:0]      r_dec_imm;
   logic            r_halted;
   logic            r_cond_flag;
   logic            r_flag_pending;

   logic [3:0]      w_opcode;
   logic [PC_W-1:0] w_imm;
   logic [PC_W-1:0] w_pc_inc;
   logic            w_xfer;
   logic            w_can_load;
   logic            w_issue_flag;
   logic            w_flag_busy;
   logic            w_cond_br;
   logic            w_is_branch;
   logic            w_taken;
   logic [PC_W-1:0] w_next_pc;
   logic            w_self_loop;

   assign w_opcode   = bus.op[OP_W-1 -: 4];
   assign w_imm      = bus.op[PC_W-1:0];
   assign w_pc_inc   = r_pc + PC_W'(1);
   assign w_xfer     = r_dec_valid && bus.dec_ready;
   assign w_can_load = !r_dec_valid || bus.dec_ready;
   assign w_cond_br  = (w_opcode == OP_JNO) || (w_opcode == OP_JNZ);

   // A COMP/CHECK leaving the output register arms the scoreboard; one still
   // sitting in the register will arm it too, so a conditional branch must
   // treat both as an unresolved flag.
   assign w_issue_flag = w_xfer && sets_flag(r_dec_opcode);
   assign w_flag_busy  = r_flag_pending || (r_dec_valid && sets_flag(r_dec_opcode));

   fd_branch_eval #(.PC_W(PC_W)) u_branch_eval (
      .i_opcode    (w_opcode),
      .i_imm       (w_imm),
      .i_pc        (r_pc),
      .i_cond_flag (r_cond_flag),
      .o_is_branch (w_is_branch),
      .o_taken     (w_taken),
      .o_next_pc   (w_next_pc),
      .o_self_loop (w_self_loop)
   );

   // Fetch FSM, pc, decoded output register and flag scoreboard.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_RUN;
         r_pc           <= '0;
         r_dec_valid    <= 1'b0;
         r_dec_opcode   <= '0;
         r_dec_dst      <= '0;
         r_dec_src1     <= '0;
         r_dec_src0     <= '0;
         r_dec_imm      <= '0;
         r_halted       <= 1'b0;
         r_cond_flag    <= 1'b0;
         r_flag_pending <= 1'b0;
      end else begin
         if (bus.flag_valid)
            r_cond_flag <= bus.flag_in;
         if (w_issue_flag)
            r_flag_pending <= 1'b1;
         else if (bus.flag_valid)
            r_flag_pending <= 1'b0;

         case (r_state)
            S_RUN: begin
               if (w_is_branch) begin
                  if (w_xfer)
                     r_dec_valid <= 1'b0;
                  if (w_cond_br && w_flag_busy) begin
                     r_state <= S_BWAIT;
                  end else begin
                     r_pc <= w_next_pc;
                     if ((HALT_SELF_JMP != 0) && w_self_loop && w_taken) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                     end
                  end
               end else if (w_can_load) begin
                  r_dec_valid  <= 1'b1;
                  r_dec_opcode <= bus.op[15:12];
                  r_dec_dst    <= bus.op[11:8];
                  r_dec_src1   <= bus.op[7:4];
                  r_dec_src0   <= bus.op[3:0];
                  r_dec_imm    <= bus.op[7:0];
                  r_pc         <= w_pc_inc;
               end else begin
                  r_state <= S_STALL;
               end
            end
            S_STALL: begin
               // Held op is still at pc, so reload it in the release cycle.
               if (bus.dec_ready) begin
                  r_dec_valid  <= 1'b1;
                  r_dec_opcode <= bus.op[15:12];
                  r_dec_dst    <= bus.op[11:8];
                  r_dec_src1   <= bus.op[7:4];
                  r_dec_src0   <= bus.op[3:0];
                  r_dec_imm    <= bus.op[7:0];
                  r_pc         <= w_pc_inc;
                  r_state      <= S_RUN;
               end
            end
            S_BWAIT: begin
               if (w_xfer)
                  r_dec_valid <= 1'b0;
               if (!w_flag_busy) begin
                  r_pc    <= w_next_pc;
                  r_state <= S_RUN;
               end
            end
            S_HALT: begin
               if (w_xfer)
                  r_dec_valid <= 1'b0;
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign bus.pc         = r_pc;
   assign bus.dec_valid  = r_dec_valid;
   assign bus.dec_opcode = r_dec_opcode;
   assign bus.dec_dst    = r_dec_dst;
   assign bus.dec_src1   = r_dec_src1;
   assign bus.dec_src0   = r_dec_src0;
   assign bus.dec_imm    = r_dec_imm;
   assign bus.halted     = r_halted;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: combinational imem array behind pc,
// hand-computed expectations checked one cycle edge at a time.
module tb_fetch_decode;
   import fetch_decode_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_decode_if #(.PC_W(8), .OP_W(16)) ifc ();

   logic [15:0] imem [256];
   assign ifc.op = imem[ifc.pc];

   fetch_decode #(.PC_W(8), .OP_W(16), .HALT_SELF_JMP(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [15:0] mk(logic [3:0] o, logic [3:0] d, logic [3:0] s1, logic [3:0] s0);
      return {o, d, s1, s0};
   endfunction

   function automatic logic [15:0] br(logic [3:0] o, logic [7:0] t);
      return {o, 4'h0, t};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem;
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
   endtask

   task automatic do_reset;
      rst            = 1'b1;
      ifc.dec_ready  = 1'b1;
      ifc.flag_valid = 1'b0;
      ifc.flag_in    = 1'b0;
      tick();
      tick();
      check("rst_pc",     32'(ifc.pc), 32'd0);
      check("rst_valid",  32'(ifc.dec_valid), 32'd0);
      check("rst_halted", 32'(ifc.halted), 32'd0);
      check("rst_opcode", 32'(ifc.dec_opcode), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      ifc.dec_ready  = 1'b1;
      ifc.flag_valid = 1'b0;
      ifc.flag_in    = 1'b0;

      // Straight line + backpressure: INC ops, dst = address.
      clear_mem();
      for (int i = 0; i < 8; i++) imem[i] = mk(OP_INC, 4'(i), 4'(i + 1), 4'(i + 2));
      do_reset();
      tick();
      check("t1_valid", 32'(ifc.dec_valid), 32'd1);
      check("t1_opc",   32'(ifc.dec_opcode), 32'(OP_INC));
      check("t1_dst",   32'(ifc.dec_dst), 32'd0);
      check("t1_src1",  32'(ifc.dec_src1), 32'd1);
      check("t1_src0",  32'(ifc.dec_src0), 32'd2);
      check("t1_pc",    32'(ifc.pc), 32'd1);
      for (int k = 1; k < 4; k++) begin
         tick();
         check("t2_valid", 32'(ifc.dec_valid), 32'd1);
         check("t2_dst",   32'(ifc.dec_dst), 32'(k));
         check("t2_pc",    32'(ifc.pc), 32'(k + 1));
      end
      ifc.dec_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t3_hold_pc",    32'(ifc.pc), 32'd4);
         check("t3_hold_dst",   32'(ifc.dec_dst), 32'd3);
         check("t3_hold_valid", 32'(ifc.dec_valid), 32'd1);
      end
      ifc.dec_ready = 1'b1;
      tick();
      check("t3_rel_dst", 32'(ifc.dec_dst), 32'd4);
      check("t3_rel_pc",  32'(ifc.pc), 32'd5);
      tick();
      check("t3_next_dst", 32'(ifc.dec_dst), 32'd5);
      check("t3_next_pc",  32'(ifc.pc), 32'd6);

      // Scoreboard: COMP at 0, JNO->6 at 1, delayed flag result.
      for (int fl = 0; fl < 2; fl++) begin
         clear_mem();
         imem[0] = mk(OP_COMP, 4'h1, 4'h2, 4'h3);
         imem[1] = br(OP_JNO, 8'd6);
         imem[2] = mk(OP_INC, 4'h2, 4'h0, 4'h0);
         imem[6] = mk(OP_INC, 4'h6, 4'h0, 4'h0);
         do_reset();
         tick();
         check("t4_comp_opc", 32'(ifc.dec_opcode), 32'(OP_COMP));
         check("t4_comp_pc",  32'(ifc.pc), 32'd1);
         tick();
         check("t4_bw_pc",    32'(ifc.pc), 32'd1);
         check("t4_bubble",   32'(ifc.dec_valid), 32'd0);
         tick();
         check("t4_wait_pc",  32'(ifc.pc), 32'd1);
         tick();
         check("t4_wait_pc",  32'(ifc.pc), 32'd1);
         ifc.flag_valid = 1'b1;
         ifc.flag_in    = fl[0];
         tick();
         check("t4_flag_pc",  32'(ifc.pc), 32'd1);
         ifc.flag_valid = 1'b0;
         tick();
         check("t4_resolve_pc", 32'(ifc.pc), fl == 0 ? 32'd6 : 32'd2);
         tick();
         check("t4_target_dst", 32'(ifc.dec_dst), fl == 0 ? 32'd6 : 32'd2);
         check("t4_target_vld", 32'(ifc.dec_valid), 32'd1);
      end

      // Same-cycle flag return and second COMP issue.
      clear_mem();
      imem[0] = mk(OP_COMP, 4'h1, 4'h0, 4'h0);
      imem[1] = mk(OP_COMP, 4'h5, 4'h0, 4'h0);
      imem[2] = br(OP_JNZ, 8'd9);
      imem[3] = mk(OP_INC, 4'h3, 4'h0, 4'h0);
      imem[9] = mk(OP_INC, 4'h9, 4'h0, 4'h0);
      do_reset();
      tick();
      check("t5_c0_dst", 32'(ifc.dec_dst), 32'd1);
      tick();
      check("t5_c1_dst", 32'(ifc.dec_dst), 32'd5);
      check("t5_c1_pc",  32'(ifc.pc), 32'd2);
      ifc.dec_ready = 1'b0;
      tick();
      check("t5_held_vld", 32'(ifc.dec_valid), 32'd1);
      check("t5_held_dst", 32'(ifc.dec_dst), 32'd5);
      check("t5_held_pc",  32'(ifc.pc), 32'd2);
      ifc.dec_ready  = 1'b1;
      ifc.flag_valid = 1'b1;
      ifc.flag_in    = 1'b1;
      tick();
      check("t5_same_pc",  32'(ifc.pc), 32'd2);
      check("t5_same_vld", 32'(ifc.dec_valid), 32'd0);
      ifc.flag_valid = 1'b0;
      tick();
      check("t5_wait_pc", 32'(ifc.pc), 32'd2);
      tick();
      check("t5_wait_pc", 32'(ifc.pc), 32'd2);
      ifc.flag_valid = 1'b1;
      ifc.flag_in    = 1'b0;
      tick();
      check("t5_flag2_pc", 32'(ifc.pc), 32'd2);
      ifc.flag_valid = 1'b0;
      tick();
      check("t5_resolve_pc", 32'(ifc.pc), 32'd3);
      tick();
      check("t5_next_dst", 32'(ifc.dec_dst), 32'd3);

      // Halt on jump-to-self at 78, final output drains afterwards.
      clear_mem();
      imem[0]  = mk(OP_INC, 4'h7, 4'h0, 4'h0);
      imem[1]  = br(OP_JMP, 8'd78);
      imem[78] = br(OP_JMP, 8'd78);
      do_reset();
      tick();
      check("t6_first_dst", 32'(ifc.dec_dst), 32'd7);
      ifc.dec_ready = 1'b0;
      tick();
      check("t6_jmp_pc",  32'(ifc.pc), 32'd78);
      check("t6_jmp_vld", 32'(ifc.dec_valid), 32'd1);
      tick();
      check("t6_halted",  32'(ifc.halted), 32'd1);
      check("t6_halt_pc", 32'(ifc.pc), 32'd78);
      check("t6_halt_vld", 32'(ifc.dec_valid), 32'd1);
      ifc.dec_ready = 1'b1;
      tick();
      check("t6_drain_vld", 32'(ifc.dec_valid), 32'd0);
      check("t6_drain_pc",  32'(ifc.pc), 32'd78);
      tick();
      check("t6_stay_pc",     32'(ifc.pc), 32'd78);
      check("t6_stay_halted", 32'(ifc.halted), 32'd1);

      // Wrap 255->0 with an unknown opcode issued as-is, then reset mid-flight.
      clear_mem();
      imem[0]   = br(OP_JMP, 8'd255);
      imem[255] = 16'hFABC;
      do_reset();
      tick();
      check("t7_jmp_pc",  32'(ifc.pc), 32'd255);
      check("t7_jmp_vld", 32'(ifc.dec_valid), 32'd0);
      tick();
      check("t7_wrap_pc", 32'(ifc.pc), 32'd0);
      check("t7_unk_vld", 32'(ifc.dec_valid), 32'd1);
      check("t7_unk_opc", 32'(ifc.dec_opcode), 32'hF);
      check("t7_unk_dst", 32'(ifc.dec_dst), 32'hA);
      check("t7_unk_s1",  32'(ifc.dec_src1), 32'hB);
      check("t7_unk_s0",  32'(ifc.dec_src0), 32'hC);
      check("t7_unk_imm", 32'(ifc.dec_imm), 32'hBC);
      ifc.dec_ready = 1'b0;
      rst = 1'b1;
      tick();
      check("t7_rst_vld", 32'(ifc.dec_valid), 32'd0);
      check("t7_rst_pc",  32'(ifc.pc), 32'd0);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
